// File: rtl/eyeriss_pkg.sv
// Shared Eyeriss definitions: psum geometry and the drain FSM state type.
package eyeriss_pkg;

  localparam int PSUM_W    = 32;
  localparam int NUM_LANES = 14;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  typedef logic signed [PSUM_W-1:0] psum_t;

endpackage

// File: rtl/psum_drain.sv
// Captures one row of PE-array partial sums in a single cycle and streams it word by word to the GLB writer.
// Optional macro PSUM_RELU_EN clamps negative words to zero on the output mux.
module psum_drain #(
  parameter int NUM_LANES = eyeriss_pkg::NUM_LANES,
  parameter int PSUM_W    = eyeriss_pkg::PSUM_W,
  parameter int ADDR_W    = 8,
  localparam int CNT_W    = $clog2(NUM_LANES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LANES*PSUM_W-1:0]   psum_in,
  input  logic                          psum_valid,
  input  logic [CNT_W-1:0]              lane_count,
  input  logic [ADDR_W-1:0]             base_addr,
  output logic [PSUM_W-1:0]             out_data,
  output logic [ADDR_W-1:0]             out_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  import eyeriss_pkg::*;

  drain_state_t      state_q, state_d;
  logic [PSUM_W-1:0] lanes_q [NUM_LANES];
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_eff;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              capture;
  logic              handshake;
  logic              last_word;
  logic [PSUM_W-1:0] lane_sel;

  // Zero or out-of-range counts mean "drain the whole row".
  always_comb begin
    cnt_eff = lane_count;
    if (lane_count == '0 || lane_count > CNT_W'(NUM_LANES)) begin
      cnt_eff = CNT_W'(NUM_LANES);
    end
  end

  always_comb begin
    capture   = psum_valid && (state_q == IDLE);
    handshake = (state_q == DRAIN) && out_ready;
    last_word = (idx_q == cnt_q - 1'b1);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (psum_valid) begin
          state_d = DRAIN;
          idx_d   = '0;
          cnt_d   = cnt_eff;
          base_d  = base_addr;
        end
      end
      DRAIN: begin
        // A capture request during a drain is dropped, including on the final handshake.
        if (psum_valid) begin
          ovf_d = 1'b1;
        end
        if (handshake) begin
          if (last_word) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lanes_q[i] <= '0;
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lanes_q[i] <= psum_in[i*PSUM_W +: PSUM_W];
      end
    end
  end

  always_comb begin
    lane_sel = lanes_q[idx_q];
`ifdef PSUM_RELU_EN
    out_data = lane_sel[PSUM_W-1] ? '0 : lane_sel;
`else
    out_data = lane_sel;
`endif
  end

  // Address arithmetic wraps modulo 2^ADDR_W by construction.
  assign out_addr  = base_q + ADDR_W'(idx_q);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign done      = done_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/psum_drain.md
# psum_drain

Collects one row of partial sums from the PE array in a single cycle and streams it out one word per cycle over a valid/ready interface toward the global buffer write port. It sits between the PE array's parallel `psum_outs` lanes and the GLB writer in `main`, replacing direct tap-and-print observation of the lanes. It gives the array a fire-and-forget capture, so the array can begin its next pass while the previous row drains.

## Interface
- `NUM_LANES`, 14: number of psum lanes from the PE array
- `PSUM_W`, 32: psum width, two's complement
- `ADDR_W`, 8: GLB word-address width

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high, one clock domain
- `psum_in`  in  NUM_LANES*PSUM_W  flattened lanes; lane i at bits [i*PSUM_W +: PSUM_W]
- `psum_valid`  in  1  capture request, single-cycle pulse
- `lane_count`  in  $clog2(NUM_LANES+1)  lanes to drain, sampled with `psum_valid`
- `base_addr`  in  ADDR_W  GLB address of lane 0, sampled with `psum_valid`
- `out_data`  out  PSUM_W  drained word
- `out_addr`  out  ADDR_W  GLB address of `out_data`
- `out_valid`  out  1  word available
- `out_ready`  in  1  GLB writer accepts word
- `busy`  out  1  capture held, drain in progress
- `done`  out  1  one-cycle pulse after the last word is accepted
- `overflow`  out  1  sticky; a capture was dropped

## Operation
- Two states: IDLE and DRAIN.
- **Capture (IDLE):**
  - `psum_valid` = 1 latches all lanes, `base_addr`, and the effective count.
  - Effective count: `lane_count` if it is in 1..NUM_LANES; 0 or any value above NUM_LANES becomes NUM_LANES.
  - Index resets to 0 and the block moves to DRAIN.
- **Drain (DRAIN):**
  - `out_data` = latched lane[index]; `out_addr` = base + index, modulo 2^ADDR_W (wraps silently).
  - A handshake is `out_valid & out_ready`; each handshake increments the index.
  - The handshake on index = count-1 returns the block to IDLE.
- **Overflow:**
  - `psum_valid` while in DRAIN is ignored, latched data is unchanged, and `overflow` sets.
  - `overflow` clears only on `rst`.
- Data passes through unmodified unless `PSUM_RELU_EN` is defined (see Configuration).

## Timing
- **Reset:** all outputs 0; state IDLE; index 0; overflow 0. Reset asserted mid-drain abandons the row. The cycle after `rst` the block is IDLE with `out_valid` = 0.
- **Capture latency:** `psum_valid` at edge N gives `out_valid` = 1 and `busy` = 1 after edge N+1, presenting word 0.
- **Stability:** while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_addr` hold.
- **Throughput:** with `out_ready` held high, one word per cycle, so count words take count cycles.
- **Completion:** in the cycle after the last handshake:
  - `done` = 1, `busy` = 0, `out_valid` = 0.
  - `psum_valid` in that same cycle is accepted as a new capture (IDLE).
- **`out_valid` in IDLE:** never asserted.
- **`psum_valid` on the last-handshake cycle:** the block is still in DRAIN, so the capture is dropped and `overflow` sets.

## Configuration
- `PSUM_RELU_EN` defined: `out_data` = 0 when the latched lane is negative (MSB = 1), otherwise the lane value. Clamping is applied on the output mux; latched data is unchanged.
- Not defined: raw psums, bit-exact.

## Structure
- **Shared package `eyeriss_pkg`:**
  - `PSUM_W`
  - `NUM_LANES`
  - state enum `drain_state_t` {IDLE, DRAIN}
  - `psum_t` typedef (signed logic [PSUM_W-1:0])
- **Single module `psum_drain`; no sub-module.** The lane-select mux and the ReLU clamp stay inline.

## Test plan
- **Basic drain:** reset 3 cycles; capture lanes i = 100+i, `lane_count` = 6, `base_addr` = 0x10, `out_ready` = 1. Expect:
  - words 100..105 at addresses 0x10..0x15 on 6 consecutive cycles
  - `done` pulse on the 7th cycle after capture
- **Backpressure:** same capture; toggle `out_ready` 1,0,0,1,… Expect every word exactly once, with data and address held during stalls.
- **Count clamp and wrap:** `lane_count` = 0 with `base_addr` = 0xFC. Expect:
  - 14 words
  - addresses 0xFC..0xFF, then 0x00..0x09
- **Overflow:** second `psum_valid` mid-drain with lanes = 0xDEAD. Expect:
  - the original row drains unchanged
  - `overflow` = 1 and stays 1
  - `rst` clears it
- **Back-to-back and reset:**
  - `psum_valid` on the `done` cycle is captured; no overflow.
  - `rst` mid-drain gives `out_valid` = 0 and `busy` = 0 the next cycle.
- **ReLU (`PSUM_RELU_EN` build):** lanes −5, 7, 0x80000000. Expect `out_data` = 0, 7, 0.
